// File: rtl/matrix_accel_sequencer.sv
// Row sequencer for a KERNEL_SIZE-lane multiply/accumulate accelerator: clear, multiply, add per row, then final reduce.
// Optional build macro SEQ_WATCHDOG_EN adds a WAIT_M timeout that raises a sticky err flag.
module matrix_accel_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_WIDTH  = $clog2(KERNEL_SIZE*KERNEL_SIZE)
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] in_row_a,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] in_row_b,
  output logic                              acc_clr,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] acc_multiplier,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] acc_multiplicand,
  output logic [KERNEL_SIZE-1:0]            acc_mstart,
  input  logic [KERNEL_SIZE-1:0]            acc_mready,
  output logic [KERNEL_SIZE-1:0]            acc_add,
  output logic [ADDR_WIDTH-1:0]             acc_addr,
  output logic                              acc_direct,
  output logic                              acc_final_add,
  input  logic [2*DATA_WIDTH-1:0]           acc_final_accum,
  input  logic                              acc_final_ready,
  output logic [2*DATA_WIDTH-1:0]           res_data,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic                              busy,
  output logic                              err
);

  localparam int RW  = KERNEL_SIZE*DATA_WIDTH;
  localparam int RCW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int DCW = $clog2(KERNEL_SIZE+2);

  typedef enum logic [2:0] {
    IDLE, CLEAR, MULT, WAIT_M, ADD, FINAL, DRAIN, OUT
  } state_e;

  state_e                  state_q;
  logic [RCW-1:0]          row_cnt_q;
  logic [DCW-1:0]          dcnt_q;
  logic                    in_ready_q, busy_q, acc_clr_q, acc_final_add_q, res_valid_q, acc_direct_q;
  logic [KERNEL_SIZE-1:0]  acc_mstart_q, acc_add_q;
  logic [RW-1:0]           mult_q, mcand_q;
  logic [2*DATA_WIDTH-1:0] res_data_q;
  logic                    last_row_d, drain_done_d;

`ifdef SEQ_WATCHDOG_EN
  logic [7:0] wd_cnt_q;
  logic       err_q;
`endif

  assign last_row_d   = (row_cnt_q == RCW'(KERNEL_SIZE-1));
  assign drain_done_d = (dcnt_q >= DCW'(KERNEL_SIZE+1));

  // Outputs are registered alongside the state, so each is loaded with the value of the state being entered.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q         <= IDLE;
      row_cnt_q       <= '0;
      dcnt_q          <= '0;
      in_ready_q      <= 1'b1;
      busy_q          <= 1'b0;
      acc_clr_q       <= 1'b0;
      acc_final_add_q <= 1'b0;
      res_valid_q     <= 1'b0;
      acc_direct_q    <= 1'b0;
      acc_mstart_q    <= '0;
      acc_add_q       <= '0;
      mult_q          <= '0;
      mcand_q         <= '0;
      res_data_q      <= '0;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt_q        <= '0;
      err_q           <= 1'b0;
`endif
    end else begin
      acc_clr_q       <= 1'b0;
      acc_final_add_q <= 1'b0;
      acc_mstart_q    <= '0;
      acc_add_q       <= '0;
      acc_direct_q    <= 1'b1;
      case (state_q)
        IDLE: if (in_valid) begin
          mult_q     <= in_row_a;
          mcand_q    <= in_row_b;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          if (row_cnt_q == '0) begin
            state_q   <= CLEAR;
            acc_clr_q <= 1'b1;
          end else begin
            state_q      <= MULT;
            acc_mstart_q <= '1;
          end
        end
        CLEAR: begin
          state_q      <= MULT;
          acc_mstart_q <= '1;
        end
        MULT: begin
          state_q <= WAIT_M;
`ifdef SEQ_WATCHDOG_EN
          wd_cnt_q <= '0;
`endif
        end
        WAIT_M: if (&acc_mready) begin
          state_q   <= ADD;
          acc_add_q <= '1;
        end else begin
`ifdef SEQ_WATCHDOG_EN
          // 255th stalled cycle: give up on the job and return to a clean row-0 start.
          if (wd_cnt_q == 8'd254) begin
            err_q      <= 1'b1;
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
`endif
        end
        ADD: if (last_row_d) begin
          state_q         <= FINAL;
          row_cnt_q       <= '0;
          acc_final_add_q <= 1'b1;
        end else begin
          state_q    <= IDLE;
          row_cnt_q  <= row_cnt_q + RCW'(1);
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        FINAL: begin
          state_q <= DRAIN;
          dcnt_q  <= '0;
        end
        DRAIN: begin
          // Counter saturates so a slow final_ready cannot wrap it below the threshold.
          if (!drain_done_d) dcnt_q <= dcnt_q + DCW'(1);
          if (drain_done_d && acc_final_ready) begin
            state_q     <= OUT;
            res_data_q  <= acc_final_accum;
            res_valid_q <= 1'b1;
          end
        end
        OUT: if (res_ready) begin
          state_q     <= IDLE;
          res_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready         = in_ready_q;
  assign busy             = busy_q;
  assign acc_clr          = acc_clr_q;
  assign acc_multiplier   = mult_q;
  assign acc_multiplicand = mcand_q;
  assign acc_mstart       = acc_mstart_q;
  assign acc_add          = acc_add_q;
  assign acc_addr         = '0;
  assign acc_direct       = acc_direct_q;
  assign acc_final_add    = acc_final_add_q;
  assign res_data         = res_data_q;
  assign res_valid        = res_valid_q;
`ifdef SEQ_WATCHDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_accel_sequencer.sv
// Directed bench for matrix_accel_sequencer with a behavioural accelerator model and a result scoreboard.
module tb_matrix_accel_sequencer;
  localparam int DW = 32;
  localparam int K  = 3;
  localparam int AW = $clog2(K*K);

  logic            Clk = 1'b0, Rst = 1'b1;
  logic            in_valid = 1'b0, in_ready;
  logic [K*DW-1:0] in_row_a = '0, in_row_b = '0;
  logic            acc_clr, acc_direct, acc_final_add, res_valid, busy, err;
  logic [K*DW-1:0] acc_multiplier, acc_multiplicand;
  logic [K-1:0]    acc_mstart, acc_add;
  logic [K-1:0]    acc_mready = '0;
  logic [AW-1:0]   acc_addr;
  logic [2*DW-1:0] acc_final_accum = '0, res_data;
  logic            acc_final_ready = 1'b0, res_ready = 1'b1;

  matrix_accel_sequencer #(.DATA_WIDTH(DW), .KERNEL_SIZE(K)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_row_a(in_row_a), .in_row_b(in_row_b), .acc_clr(acc_clr),
    .acc_multiplier(acc_multiplier), .acc_multiplicand(acc_multiplicand),
    .acc_mstart(acc_mstart), .acc_mready(acc_mready), .acc_add(acc_add),
    .acc_addr(acc_addr), .acc_direct(acc_direct), .acc_final_add(acc_final_add),
    .acc_final_accum(acc_final_accum), .acc_final_ready(acc_final_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .err(err));

  always #5 Clk = ~Clk;

  int nvec = 0, nerr = 0;
  logic [2*DW-1:0] sb[$];

  task automatic chk(input string tag, input logic [2*DW-1:0] obs, input logic [2*DW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accelerator model: per-lane multiply with lane-staggered latency, accumulators, final sum.
  int mlat = 2;
  bit stuck = 1'b0;
  int lat[K];
  logic [2*DW-1:0] prod[K], acc[K];
  initial for (int n = 0; n < K; n++) begin lat[n] = 0; prod[n] = '0; acc[n] = '0; end

  always @(posedge Clk) begin
    logic [2*DW-1:0] s;
    s = '0;
    for (int n = 0; n < K; n++) begin
      s = s + acc[n];
      if (acc_clr) acc[n] <= '0;
      if (acc_add[n]) acc[n] <= acc[n] + prod[n];
      if (acc_mstart[n]) begin
        prod[n] <= (2*DW)'(acc_multiplier[n*DW +: DW]) * (2*DW)'(acc_multiplicand[n*DW +: DW]);
        acc_mready[n] <= 1'b0;
        lat[n] <= mlat + n;
      end else if (stuck) begin
        acc_mready[n] <= 1'b0;
      end else if (lat[n] > 0) begin
        lat[n] <= lat[n] - 1;
        if (lat[n] == 1) acc_mready[n] <= 1'b1;
      end
    end
    if (acc_clr) acc_final_ready <= 1'b0;
    if (acc_final_add) begin
      acc_final_accum <= s;
      acc_final_ready <= 1'b1;
    end
  end

  // Monitor: pulse counters and scoreboard pop on each completed result handshake.
  int c_clr = 0, c_ms = 0, c_add = 0, c_fin = 0, c_rv = 0, nres = 0;
  always @(negedge Clk) begin
    if (acc_clr) c_clr++;
    if (acc_mstart == {K{1'b1}}) c_ms++;
    if (acc_add == {K{1'b1}}) c_add++;
    if (acc_final_add) c_fin++;
    if (res_valid) c_rv++;
    if (res_valid && res_ready) begin
      nres++;
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else chk("res_data", res_data, sb.pop_front());
    end
  end

  task automatic tick;
    @(posedge Clk); #1;
  endtask

  function automatic logic [K*DW-1:0] row(input int x0, input int x1, input int x2);
    return {DW'(x2), DW'(x1), DW'(x0)};
  endfunction

  function automatic logic [2*DW-1:0] dot(input logic [K*DW-1:0] a, input logic [K*DW-1:0] b);
    logic [2*DW-1:0] s;
    s = '0;
    for (int n = 0; n < K; n++) s = s + (2*DW)'(a[n*DW +: DW]) * (2*DW)'(b[n*DW +: DW]);
    return s;
  endfunction

  // Present a row with in_valid held and return just after the accepting edge.
  task automatic send_row(input logic [K*DW-1:0] a, input logic [K*DW-1:0] b);
    int g;
    in_valid = 1'b1; in_row_a = a; in_row_b = b;
    g = 0;
    while (!in_ready && g < 300) begin tick; g++; end
    chk("in_ready_wait", in_ready, 1);
    tick;
  endtask

  task automatic wait_res(input int target);
    int g;
    g = 0;
    while (nres < target && g < 300) begin tick; g++; end
    chk("result_arrived", (nres >= target), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [K*DW-1:0] ra[K], rb[K];
    logic [2*DW-1:0] e;
    int b_clr, b_ms, b_add, b_fin, b_rv, g;

    // Reset values
    tick; tick;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_clr", acc_clr, 0);
    chk("rst_mstart", acc_mstart, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_direct", acc_direct, 0);
    chk("rst_err", err, 0);
    Rst = 1'b0;
    tick;
    chk("direct_const", acc_direct, 1);
    chk("addr_const", acc_addr, 0);

    // Job 1: a={1,2,3},{4,5,6},{7,8,9}, b all ones, valid held high at start
    b_clr = c_clr; b_ms = c_ms; b_add = c_add; b_fin = c_fin; b_rv = c_rv;
    ra[0] = row(1,2,3); ra[1] = row(4,5,6); ra[2] = row(7,8,9);
    for (int r = 0; r < K; r++) rb[r] = row(1,1,1);
    e = '0;
    for (int r = 0; r < K; r++) e = e + dot(ra[r], rb[r]);
    chk("model_sum_45", e, 45);
    sb.push_back(e);
    send_row(ra[0], rb[0]);
    chk("r0_clr_t1", acc_clr, 1);
    chk("r0_mstart_t1", acc_mstart, 0);
    chk("r0_in_ready", in_ready, 0);
    chk("r0_busy", busy, 1);
    chk("r0_mult_reg", acc_multiplier, ra[0]);
    tick;
    chk("r0_mstart_t2", acc_mstart, 3'b111);
    chk("r0_clr_t2", acc_clr, 0);
    tick;
    chk("r0_mstart_1cyc", acc_mstart, 0);
    send_row(ra[1], rb[1]);
    chk("r1_mstart_t1", acc_mstart, 3'b111);
    chk("r1_clr", acc_clr, 0);
    chk("r1_mcand_reg", acc_multiplicand, rb[1]);
    send_row(ra[2], rb[2]);
    in_valid = 1'b0;
    wait_res(1);
    chk("j1_clr_cnt", c_clr - b_clr, 1);
    chk("j1_mstart_cnt", c_ms - b_ms, 3);
    chk("j1_add_cnt", c_add - b_add, 3);
    chk("j1_final_cnt", c_fin - b_fin, 1);
    chk("j1_rv_one_cycle", c_rv - b_rv, 1);
    chk("j1_idle_ready", in_ready, 1);
    chk("j1_idle_busy", busy, 0);
    chk("j1_rv_low", res_valid, 0);

    // Job 2: varied operands, result held back for 10 cycles
    res_ready = 1'b0;
    e = '0;
    for (int r = 0; r < K; r++) begin
      ra[r] = row($urandom_range(0, 100000), $urandom_range(0, 100000), $urandom_range(0, 100000));
      rb[r] = row($urandom_range(0, 100000), $urandom_range(0, 100000), $urandom_range(0, 100000));
      e = e + dot(ra[r], rb[r]);
    end
    sb.push_back(e);
    for (int r = 0; r < K; r++) send_row(ra[r], rb[r]);
    in_valid = 1'b0;
    g = 0;
    while (!res_valid && g < 300) begin tick; g++; end
    for (int i = 0; i < 10; i++) begin
      chk("stall_rv", res_valid, 1);
      chk("stall_data", res_data, e);
      chk("stall_in_ready", in_ready, 0);
      tick;
    end
    res_ready = 1'b1;
    wait_res(2);
    chk("j2_rv_low", res_valid, 0);

    // Job 3: reset during WAIT_M of row 1 aborts the job
    mlat = 20;
    send_row(row(3,3,3), row(3,3,3));
    send_row(row(3,3,3), row(3,3,3));
    in_valid = 1'b0;
    tick; tick;
    chk("abort_busy_pre", busy, 1);
    Rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_mstart", acc_mstart, 0);
    chk("abort_mult", acc_multiplier, 0);
    chk("abort_res_data", res_data, 0);
    tick;
    Rst = 1'b0;
    mlat = 1;

    // Job 4: a=b={2,2,2} x3 after abort, must restart at row 0
    e = '0;
    for (int r = 0; r < K; r++) e = e + dot(row(2,2,2), row(2,2,2));
    chk("model_sum_36", e, 36);
    sb.push_back(e);
    send_row(row(2,2,2), row(2,2,2));
    chk("j4_row0_clr", acc_clr, 1);
    send_row(row(2,2,2), row(2,2,2));
    send_row(row(2,2,2), row(2,2,2));
    in_valid = 1'b0;
    wait_res(3);
    repeat (20) tick;
    chk("total_results", nres, 3);
    chk("sb_empty", sb.size(), 0);
    chk("err_low", err, 0);

`ifdef SEQ_WATCHDOG_EN
    stuck = 1'b1;
    send_row(row(1,1,1), row(1,1,1));
    in_valid = 1'b0;
    g = 0;
    while (!err && g < 400) begin tick; g++; end
    chk("wd_err", err, 1);
    chk("wd_busy", busy, 0);
    chk("wd_in_ready", in_ready, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
